// File: rtl/fir_xifu_issue_queue.sv
// fir_xifu_issue_queue
// XIF issue/decode stage of the FIR XIFU. It decodes xfirlw / xfirsw / xfirdotp, answers the
// issue response combinationally, buffers accepted instructions in a DEPTH-entry FIFO and hands
// them to fir_xifu_ex over a valid/ready handshake. Entries can be killed by id from the commit
// interface and the whole queue can be flushed with clear_i.
// Optional build macro FIR_XIFU_ISSUE_BYPASS_EN: when the FIFO is empty and EX is ready, an
// accepted issue is forwarded to ex_* in the same cycle without being stored.
module fir_xifu_issue_queue #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned XLEN    = 32,
   parameter int unsigned ID_W    = 4,
   parameter logic [6:0]  OPCODE  = 7'h0B,
   parameter logic [2:0]  F3_LW   = 3'b000,
   parameter logic [2:0]  F3_SW   = 3'b001,
   parameter logic [2:0]  F3_DOTP = 3'b010
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clear_i,
   // XIF issue
   input  logic                     issue_valid_i,
   output logic                     issue_ready_o,
   input  logic [31:0]              issue_instr_i,
   input  logic [XLEN-1:0]          issue_rs0_i,
   input  logic [ID_W-1:0]          issue_id_i,
   output logic                     issue_accept_o,
   output logic                     issue_wb_o,
   output logic                     issue_ls_o,
   // XIF commit
   input  logic                     commit_valid_i,
   input  logic [ID_W-1:0]          commit_id_i,
   input  logic                     commit_kill_i,
   // towards EX
   output logic                     ex_valid_o,
   input  logic                     ex_ready_i,
   output logic [1:0]               ex_instr_o,
   output logic [XLEN-1:0]          ex_base_o,
   output logic [XLEN-1:0]          ex_offset_o,
   output logic [4:0]               ex_rs1_o,
   output logic [4:0]               ex_rs2_o,
   output logic [4:0]               ex_rd_o,
   output logic [ID_W-1:0]          ex_id_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   localparam logic [1:0] INSTR_INVALID = 2'd0;
   localparam logic [1:0] INSTR_LW      = 2'd1;
   localparam logic [1:0] INSTR_SW      = 2'd2;
   localparam logic [1:0] INSTR_DOTP    = 2'd3;

   // ------------------------------------------------------------------
   // Decode of the incoming issue word
   // ------------------------------------------------------------------
   logic [6:0]       w_opcode;
   logic [2:0]       w_funct3;
   logic [1:0]       w_dec_instr;
   logic             w_dec_ls;
   logic [XLEN-1:0]  w_imm_i;
   logic [XLEN-1:0]  w_imm_s;
   logic [XLEN-1:0]  w_dec_offset;
   logic [4:0]       w_dec_rs1;
   logic [4:0]       w_dec_rs2;
   logic [4:0]       w_dec_rd;

   assign w_opcode  = issue_instr_i[6:0];
   assign w_funct3  = issue_instr_i[14:12];
   assign w_dec_rd  = issue_instr_i[11:7];
   assign w_dec_rs1 = issue_instr_i[19:15];
   assign w_dec_rs2 = issue_instr_i[24:20];

   // Classify the issue word; anything outside our opcode/funct3 set decodes as INVALID.
   always_comb begin
      w_dec_instr = INSTR_INVALID;
      if (w_opcode == OPCODE) begin
         if (w_funct3 == F3_LW) begin
            w_dec_instr = INSTR_LW;
         end else if (w_funct3 == F3_SW) begin
            w_dec_instr = INSTR_SW;
         end else if (w_funct3 == F3_DOTP) begin
            w_dec_instr = INSTR_DOTP;
         end
      end
   end

   // Stores carry the S-type split immediate, everything else the I-type one.
   assign w_imm_i      = {{(XLEN-12){issue_instr_i[31]}}, issue_instr_i[31:20]};
   assign w_imm_s      = {{(XLEN-12){issue_instr_i[31]}}, issue_instr_i[31:25], issue_instr_i[11:7]};
   assign w_dec_offset = (w_dec_instr == INSTR_SW) ? w_imm_s : w_imm_i;
   assign w_dec_ls     = (w_dec_instr == INSTR_LW) || (w_dec_instr == INSTR_SW);

   assign issue_accept_o = issue_valid_i & (w_dec_instr != INSTR_INVALID);
   assign issue_wb_o     = issue_valid_i & w_dec_ls;
   assign issue_ls_o     = issue_valid_i & w_dec_ls;

   // ------------------------------------------------------------------
   // FIFO state
   // ------------------------------------------------------------------
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [LVL_W-1:0] r_level;
   logic [LVL_W-1:0] w_level_next;
   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] r_killed;

   logic [1:0]       r_instr  [DEPTH];
   logic [XLEN-1:0]  r_base   [DEPTH];
   logic [XLEN-1:0]  r_offset [DEPTH];
   logic [4:0]       r_rs1    [DEPTH];
   logic [4:0]       r_rs2    [DEPTH];
   logic [4:0]       r_rd     [DEPTH];
   logic [ID_W-1:0]  r_id     [DEPTH];

   logic             w_head_live;
   logic             w_head_dead;
   logic             w_bypass;
   logic             w_push;
   logic             w_pop;
   logic             w_remove;
   logic             w_kill;

   // Ready depends on registered occupancy only: a full queue stays closed even while popping.
   assign issue_ready_o = (r_level < LVL_W'(DEPTH));
   assign level_o       = r_level;

   // The head is presented to EX only if it has not been killed; a killed head is dropped.
   assign w_head_live = r_valid[r_rptr] & ~r_killed[r_rptr];
   assign w_head_dead = r_valid[r_rptr] &  r_killed[r_rptr];

`ifdef FIR_XIFU_ISSUE_BYPASS_EN
   assign w_bypass = issue_valid_i & (w_dec_instr != INSTR_INVALID) &
                     (r_level == '0) & ex_ready_i;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_push   = issue_valid_i & issue_ready_o & (w_dec_instr != INSTR_INVALID) & ~w_bypass;
   assign w_pop    = w_head_live & ex_ready_i;
   assign w_remove = w_pop | w_head_dead;
   assign w_kill   = commit_valid_i & commit_kill_i;

   // Next occupancy: push and removal in the same cycle cancel out.
   always_comb begin
      w_level_next = r_level;
      if (w_push && !w_remove) begin
         w_level_next = r_level + LVL_W'(1);
      end else if (!w_push && w_remove) begin
         w_level_next = r_level - LVL_W'(1);
      end
   end

   // Pointers and occupancy; clear_i has priority over any push/pop in the same cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else if (clear_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (w_remove) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         r_level <= w_level_next;
      end
   end

   // Per-entry valid/killed flags; a freshly pushed entry is never killed by a same-cycle commit.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid  <= '0;
         r_killed <= '0;
      end else if (clear_i) begin
         r_valid  <= '0;
         r_killed <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_push && (r_wptr == PTR_W'(i))) begin
               r_valid[i]  <= 1'b1;
               r_killed[i] <= 1'b0;
            end else if (w_remove && (r_rptr == PTR_W'(i))) begin
               r_valid[i]  <= 1'b0;
               r_killed[i] <= 1'b0;
            end else if (w_kill && r_valid[i] && (r_id[i] == commit_id_i)) begin
               r_killed[i] <= 1'b1;
            end
         end
      end
   end

   // Payload storage, written on push only; the valid flags decide whether it is meaningful.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_instr[r_wptr]  <= w_dec_instr;
         r_base[r_wptr]   <= issue_rs0_i;
         r_offset[r_wptr] <= w_dec_offset;
         r_rs1[r_wptr]    <= w_dec_rs1;
         r_rs2[r_wptr]    <= w_dec_rs2;
         r_rd[r_wptr]     <= w_dec_rd;
         r_id[r_wptr]     <= issue_id_i;
      end
   end

   // EX outputs: live head first, otherwise the bypassed issue, otherwise all zero.
   always_comb begin
      ex_valid_o  = 1'b0;
      ex_instr_o  = INSTR_INVALID;
      ex_base_o   = '0;
      ex_offset_o = '0;
      ex_rs1_o    = '0;
      ex_rs2_o    = '0;
      ex_rd_o     = '0;
      ex_id_o     = '0;
      if (w_head_live) begin
         ex_valid_o  = 1'b1;
         ex_instr_o  = r_instr[r_rptr];
         ex_base_o   = r_base[r_rptr];
         ex_offset_o = r_offset[r_rptr];
         ex_rs1_o    = r_rs1[r_rptr];
         ex_rs2_o    = r_rs2[r_rptr];
         ex_rd_o     = r_rd[r_rptr];
         ex_id_o     = r_id[r_rptr];
      end else if (w_bypass) begin
         ex_valid_o  = 1'b1;
         ex_instr_o  = w_dec_instr;
         ex_base_o   = issue_rs0_i;
         ex_offset_o = w_dec_offset;
         ex_rs1_o    = w_dec_rs1;
         ex_rs2_o    = w_dec_rs2;
         ex_rd_o     = w_dec_rd;
         ex_id_o     = issue_id_i;
      end
   end

endmodule
